// File: rtl/phase_sample_window_pkg.sv
// Shared definitions for the phase sampler with measurement window.
package phase_sample_window_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StMeasure = 2'd2,
    StDone    = 2'd3
  } state_e;

  // Increment unless already at or above the ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] ceil);
    return (val >= ceil) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/phase_sample_window_cell.sv
// One spin channel: mismatch detect, up/down saturating counter, hysteretic phase flag.
module phase_track_cell
  import phase_sample_window_pkg::*;
#(
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          ver_i,
  input  logic          hor_i,
  input  logic [CW-1:0] counter_max_i,
  input  logic [CW-1:0] cutoff_hi_i,
  input  logic [CW-1:0] cutoff_lo_i,
  output logic          mismatch_o,
  output logic          phase_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q;

  assign mismatch_o = ver_i ^ hor_i;
  assign phase_o    = phase_q;

  always_comb begin
    cnt_d = cnt_q;
    if (mismatch_o) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = CW'(sat_inc(32'(cnt_q), 32'(counter_max_i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q   <= cutoff_hi_i;
      phase_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      // Decision uses the pre-update count; set wins if the cutoffs are inverted.
      if (cnt_q >= cutoff_hi_i)     phase_q <= 1'b1;
      else if (cnt_q < cutoff_lo_i) phase_q <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_sample_window.sv
// Per-spin phase tracking plus a start-triggered settle/measure window that counts
// mismatch cycles per spin and hands them out over valid/ready.
module phase_sample_window
  import phase_sample_window_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 16,
  parameter int unsigned WW = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [WW-1:0]   settle_len,
  input  logic [WW-1:0]   window_len,
  input  logic [CW-1:0]   counter_max,
  input  logic [CW-1:0]   cutoff_hi,
  input  logic [CW-1:0]   cutoff_lo,
  input  logic [N-1:0]    outputs_ver,
  input  logic [N-1:0]    outputs_hor,
  output logic [N-1:0]    phase,
  output logic [N*CW-1:0] mismatch_count,
  output logic            busy,
  output logic            valid,
  input  logic            ready
);

  logic [N-1:0] mismatch;

  for (genvar g = 0; g < N; g++) begin : gen_cell
    phase_track_cell #(
      .CW(CW)
    ) u_cell (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .ver_i        (outputs_ver[g]),
      .hor_i        (outputs_hor[g]),
      .counter_max_i(counter_max),
      .cutoff_hi_i  (cutoff_hi),
      .cutoff_lo_i  (cutoff_lo),
      .mismatch_o   (mismatch[g]),
      .phase_o      (phase[g])
    );
  end

  state_e         state_q;
  logic [WW-1:0]  settle_q, win_q, cnt_q;
  logic [CW-1:0]  acc_q [N];
  logic [CW-1:0]  acc_d [N];
  logic [N*CW-1:0] count_q;
  logic           busy_q, valid_q;

  assign mismatch_count = count_q;
  assign busy           = busy_q;
  assign valid          = valid_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc_d[i] = acc_q[i];
      if (mismatch[i]) acc_d[i] = CW'(sat_inc(32'(acc_q[i]), 32'({CW{1'b1}})));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      settle_q <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '{default: '0};
      count_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            settle_q <= settle_len;
            win_q    <= (window_len == '0) ? WW'(1) : window_len;
            cnt_q    <= '0;
            acc_q    <= '{default: '0};
            busy_q   <= 1'b1;
            state_q  <= (settle_len == '0) ? StMeasure : StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == settle_q - WW'(1)) begin
            cnt_q   <= '0;
            state_q <= StMeasure;
          end else begin
            cnt_q <= cnt_q + WW'(1);
          end
        end
        StMeasure: begin
          acc_q <= acc_d;
          if (cnt_q == win_q - WW'(1)) begin
            for (int i = 0; i < N; i++) count_q[i*CW +: CW] <= acc_d[i];
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + WW'(1);
          end
        end
        StDone: begin
          if (ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sample_window.sv
// Randomised and directed checks of phase_sample_window against a cycle-timeline model.
module tb_phase_sample_window;

  logic        clk = 1'b0;
  logic        rstn, start, ready;
  logic [31:0] settle_len, window_len;
  logic [15:0] counter_max, cutoff_hi, cutoff_lo;
  logic [2:0]  ver, hor;
  logic [2:0]  phase, phase4;
  logic [47:0] mc;
  logic [11:0] mc4;
  logic        busy, valid, busy4, valid4;

  always #5 clk = ~clk;

  phase_sample_window #(.N(3), .CW(16), .WW(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .settle_len(settle_len), .window_len(window_len),
    .counter_max(counter_max), .cutoff_hi(cutoff_hi), .cutoff_lo(cutoff_lo),
    .outputs_ver(ver), .outputs_hor(hor), .phase(phase), .mismatch_count(mc),
    .busy(busy), .valid(valid), .ready(ready)
  );

  phase_sample_window #(.N(3), .CW(4), .WW(32)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .settle_len(settle_len), .window_len(window_len),
    .counter_max(counter_max[3:0]), .cutoff_hi(cutoff_hi[3:0]), .cutoff_lo(cutoff_lo[3:0]),
    .outputs_ver(ver), .outputs_hor(hor), .phase(phase4), .mismatch_count(mc4),
    .busy(busy4), .valid(valid4), .ready(ready)
  );

  int total = 0;
  int bad   = 0;

  // Model: counters as plain integers; the run is a timeline of edges since start.
  int       cnt_m [3];
  bit [2:0] phase_m;
  int       acc_m [3];
  int       res_m [3];
  bit       running, done;
  int       t, s_len, w_len;
  bit       chk_en = 1'b0;
  bit       ph4_en = 1'b0;

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        cnt_m[i] = int'(cutoff_hi);
        res_m[i] = 0;
      end
      phase_m = 3'b111;
      running = 0;
      done    = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit mm = ver[i] ^ hor[i];
        int old = cnt_m[i];
        if (old >= int'(cutoff_hi))     phase_m[i] = 1'b1;
        else if (old < int'(cutoff_lo)) phase_m[i] = 1'b0;
        if (mm) cnt_m[i] = (old == 0) ? 0 : old - 1;
        else    cnt_m[i] = (old >= int'(counter_max)) ? old : old + 1;
      end
      if (done) begin
        if (ready) done = 0;
      end else if (running) begin
        t++;
        if (t > s_len && t <= s_len + w_len)
          for (int i = 0; i < 3; i++) acc_m[i] += int'(ver[i] ^ hor[i]);
        if (t == s_len + w_len) begin
          running = 0;
          done    = 1;
          for (int i = 0; i < 3; i++) res_m[i] = acc_m[i];
        end
      end else if (start) begin
        running = 1;
        t       = 0;
        s_len   = int'(settle_len);
        w_len   = (window_len == 0) ? 1 : int'(window_len);
        for (int i = 0; i < 3; i++) acc_m[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Waits for valid; returns edges counted from the start edge (inclusive), or -1 on timeout.
  task automatic start_and_wait(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!valid) begin
      chk("valid_timeout", 0, 1);
      lat = -1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("phase[%0d]", i), phase[i], phase_m[i]);
        chk($sformatf("count[%0d]", i), mc[i*16 +: 16], sat(res_m[i], 16));
        chk($sformatf("count4[%0d]", i), mc4[i*4 +: 4], sat(res_m[i], 4));
        if (ph4_en) chk($sformatf("phase4[%0d]", i), phase4[i], phase_m[i]);
      end
      chk("busy", busy, running);
      chk("valid", valid, done);
      chk("busy4", busy4, running);
      chk("valid4", valid4, done);
    end
  end

  int lat;
  bit alt;

  initial begin
    rstn = 0; start = 0; ready = 0; settle_len = 0; window_len = 0;
    counter_max = 16; cutoff_hi = 8; cutoff_lo = 4; ver = 0; hor = 0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_phase", phase, 3'b111);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", mc, 0);

    // Matching inputs: phase stays set while counters climb to 16.
    rstn = 1;
    repeat (10) tick();
    chk("match_phase", phase, 3'b111);

    // Constant mismatch on ch0 from 16: clears after pre-count 3 (14th edge).
    ver = 3'b001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 13) chk("mm_hold_k13", phase[0], 1);
      if (k == 14) chk("mm_clear_k14", phase[0], 0);
    end
    // Back to match from 0: sets after pre-count 8 (9th edge).
    ver = 3'b000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 8) chk("hyst_low_k8", phase[0], 0);
      if (k == 9) chk("hyst_set_k9", phase[0], 1);
    end

    // Settle 5, window 10, ch1 mismatching every other cycle.
    settle_len = 5; window_len = 10;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    alt = 1'b0;
    while (!valid && lat < 100) begin
      alt = ~alt;
      ver = {1'b0, alt, 1'b0};
      tick();
      lat++;
    end
    ver = 0;
    chk("lat_5_10", lat, 16);
    chk("alt_ch1", mc[31:16], 5);
    chk("alt_ch0", mc[15:0], 0);
    chk("alt_ch2", mc[47:32], 0);
    ready = 1;
    tick();
    ready = 0;
    chk("ack_valid", valid, 0);

    // Zero-length settle and window: one measured cycle.
    settle_len = 0; window_len = 0; ver = 3'b111;
    start_and_wait(lat);
    chk("lat_0_0", lat, 2);
    chk("win0_ch0", mc[15:0], 1);
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);
      tick();
      chk("hold_valid", valid, 1);
      chk("hold_ch0", mc[15:0], 1);
    end
    start = 1; ready = 1;
    tick();
    start = 0; ready = 0;
    chk("ack_start_ignored", busy, 0);
    chk("ack_valid0", valid, 0);

    // Long window: CW=4 instance saturates at 15.
    settle_len = 0; window_len = 40;
    start_and_wait(lat);
    chk("sat4_ch0", mc4[3:0], 15);
    chk("long_ch0", mc[15:0], 40);
    ready = 1; tick(); ready = 0;

    // Reset during MEASURE aborts; a fresh run then completes.
    settle_len = 3; window_len = 20;
    start = 1; tick(); start = 0;
    repeat (6) tick();
    rstn = 0; tick(); rstn = 1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_count", mc, 0);
    chk("abort_phase", phase, 3'b111);
    settle_len = 2; window_len = 4;
    start_and_wait(lat);
    chk("fresh_lat", lat, 7);
    chk("fresh_ch0", mc[15:0], 4);
    ready = 1; tick(); ready = 0;

    // Random phase: keep thresholds within 4 bits so the narrow instance tracks too.
    counter_max = 12; cutoff_hi = 6; cutoff_lo = 3;
    rstn = 0; tick(); rstn = 1;
    ph4_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      ver = 3'($urandom); hor = 3'($urandom);
      start = ($urandom_range(7) == 0);
      ready = $urandom_range(1);
      settle_len = $urandom_range(6);
      window_len = $urandom_range(8);
      if ($urandom_range(15) == 0) begin
        counter_max = 16'($urandom_range(15));
        cutoff_hi   = 16'($urandom_range(15));
        cutoff_lo   = ($urandom_range(7) == 0) ? 16'($urandom_range(15))
                                               : 16'($urandom_range(int'(cutoff_hi)));
      end
      rstn = ($urandom_range(199) != 0);
      tick();
    end
    rstn = 1; start = 0; ready = 1;
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_sample_window.md
Name: phase_sample_window

Overview:
Successor to the single-cutoff phase sampler for the ising array.
- Per-spin phase tracking with a parametrised saturating up/down counter and hysteretic in/out-of-phase decision.
- Adds a start-triggered measurement window (settle, then measure) that counts mismatch cycles per spin and returns the counts over a valid/ready handshake.
- Sits between the coupled-oscillator array (outputs_ver/outputs_hor) and the readout/control logic.

Parameters:
N, 3, number of spins/channels
CW, 16, width of per-channel phase counters and mismatch counts
WW, 32, width of settle/window length and window counter

Ports:
clk  input  1  sampling clock
rstn  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a measurement (honoured only in IDLE)
settle_len  input  WW  cycles to wait before measuring; 0 = no settle
window_len  input  WW  measurement cycles; 0 treated as 1
counter_max  input  CW  phase-counter saturation ceiling
cutoff_hi  input  CW  counter value at/above which phase sets to 1
cutoff_lo  input  CW  counter value below which phase clears to 0; must be <= cutoff_hi
outputs_ver  input  N  spin oscillator outputs
outputs_hor  input  N  local-field oscillator outputs
phase  output  N  1 = in phase with local field, 0 = out of phase (registered)
mismatch_count  output  N*CW  channel i at [i*CW +: CW]; mismatch cycles in last window
busy  output  1  high in SETTLE or MEASURE
valid  output  1  mismatch_count holds a completed result
ready  input  1  consumer accepts the result

Behaviour:
- Reset (rstn=0 at posedge):
  - Phase counters load cutoff_hi.
  - phase = all 1s.
  - mismatch_count = 0.
  - FSM = IDLE; busy = 0; valid = 0.
- mismatch[i] = outputs_ver[i] ^ outputs_hor[i], sampled every cycle regardless of FSM state.
- Phase counter[i], per cycle:
  - If mismatch, decrement; hold at 0.
  - Otherwise increment; hold when >= counter_max.
  - If counter_max is lowered below the current value, the counter still decrements on mismatch and never increments.
- phase[i] register, updated from the counter's current (pre-update) value:
  - Set when counter >= cutoff_hi.
  - Clear when counter < cutoff_lo.
  - Otherwise hold.
  - Net result: phase lags the counter by one cycle.
  - If cutoff_lo > cutoff_hi (illegal), set takes priority.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - start=1 with settle_len=0 goes to MEASURE.
  - start=1 with settle_len>0 goes to SETTLE.
  - Entering either state captures settle_len and window_len into internal registers and clears the window counter and accumulators.
  - Input changes after capture have no effect on the run in progress.
- SETTLE: stays exactly settle_len cycles, then goes to MEASURE.
- MEASURE:
  - Stays exactly max(window_len,1) cycles.
  - Each cycle, accumulator[i] += mismatch[i], saturating at 2^CW-1.
  - On the last cycle the final increment is included.
  - mismatch_count is loaded from the accumulators on the transition to DONE.
- DONE:
  - valid = 1 and mismatch_count is stable.
  - On valid & ready, go to IDLE and drop valid the next cycle.
- mismatch_count holds its last value in IDLE until the next DONE.
- start is ignored outside IDLE, including in DONE and the cycle valid & ready fires.
- busy = (state==SETTLE || state==MEASURE).
- Latency from the start pulse to valid: settle_len + max(window_len,1) + 1 cycles.
- Reset asserted mid-operation aborts the run; all state returns to the reset values above.

Decomposition:
- Shared package: FSM state encoding localparams (S_IDLE=0, S_SETTLE=1, S_MEASURE=2, S_DONE=3).
- Shared package: saturating-increment helper function.
- Natural sub-module: phase_track_cell, one instance per channel in a generate loop.
  - Contains the mismatch XOR, the up/down saturating counter and the hysteresis phase register.
  - Exports mismatch to the window accumulator logic in the top.

Test Plan:
- Reset, then outputs_ver==outputs_hor, cutoff_hi=8, cutoff_lo=4, counter_max=16 -> phase stays 1; counter saturates at 16 within 8 cycles; busy=0, valid=0.
- Constant mismatch on ch0 from a counter of 16 -> phase[0] stays 1 through counter 4, goes 0 the cycle after the counter reads 3; counter holds at 0. Then constant match -> phase[0] returns to 1 the cycle after the counter reads 8 (hysteresis).
- settle_len=5, window_len=10, ch1 mismatching on alternating cycles -> valid asserts 16 cycles after start; mismatch_count[ch1]=5; channels that always match read 0.
- window_len=0, settle_len=0, constant mismatch -> valid after 2 cycles, count=1. Hold ready=0 for 20 cycles with a start pulse inside them -> valid and data stable, start ignored. ready=1 -> IDLE next cycle.
- CW=4, window_len=40, constant mismatch -> count saturates at 15.
- rstn low for one cycle during MEASURE -> busy=0, valid=0, mismatch_count=0, phase all 1s next cycle. A fresh start then completes normally.
